// File: rtl/md_unit_pkg.sv
// Shared op codes and helpers for the multiply/divide unit.
// Optional multiply-accumulate ops are gated by MD_MADD_EN in md_unit.
package md_unit_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd5;
  localparam logic [3:0] MD_MTLO  = 4'd6;
  localparam logic [3:0] MD_MADD  = 4'd7;
  localparam logic [3:0] MD_MADDU = 4'd8;
  localparam logic [3:0] MD_MSUB  = 4'd9;
  localparam logic [3:0] MD_MSUBU = 4'd10;

  function automatic logic is_mac_op(input logic [3:0] op);
    return (op == MD_MADD) || (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
  endfunction

endpackage

// File: rtl/md_div_core.sv
// Combinational 32-bit divide, signed or unsigned, with zero-divisor and
// signed-overflow results fixed to the ISA-defined values.
module md_div_core
  import md_unit_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sgn,
  output logic [31:0] quo,
  output logic [31:0] rem
);

  logic [31:0] ua, ub, uq, ur;
  logic        neg_q, neg_r;

  always_comb begin
    neg_q = sgn && (a[31] ^ b[31]);
    neg_r = sgn && a[31];
    ua    = (sgn && a[31]) ? (~a + 32'd1) : a;
    ub    = (sgn && b[31]) ? (~b + 32'd1) : b;
    uq    = '0;
    ur    = '0;
    quo   = '0;
    rem   = '0;
    if (b == 32'd0) begin
      quo = 32'hFFFF_FFFF;
      rem = a;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      quo = 32'h8000_0000;
      rem = 32'd0;
    end else begin
      uq  = ua / ub;
      ur  = ua % ub;
      // Truncate toward zero: quotient sign from operand signs, remainder follows dividend.
      quo = neg_q ? (~uq + 32'd1) : uq;
      rem = neg_r ? (~ur + 32'd1) : ur;
    end
  end

endmodule

// File: rtl/md_unit.sv
// Fixed-latency multiply/divide unit owning HI/LO; busy while an op is in flight.
// Define MD_MADD_EN to enable MADD/MADDU/MSUB/MSUBU; otherwise those codes are ignored.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        startE,
  input  logic [3:0]  md_op,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  input  logic        E_valid,
  input  logic        flush,
  input  logic        hl_sel,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] hl_out
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  logic [3:0]    op_q;
  logic [31:0]   a_q, b_q;
  logic [CW-1:0] cnt;

  logic          is_mul, is_div, is_mt, is_mac, op_ok, accept;
  logic [63:0]   prod_s, prod_u, acc, result;
  logic [31:0]   dq, dr;

  always_comb begin
    is_mul = (md_op == MD_MULT) || (md_op == MD_MULTU);
    is_div = (md_op == MD_DIV)  || (md_op == MD_DIVU);
    is_mt  = (md_op == MD_MTHI) || (md_op == MD_MTLO);
`ifdef MD_MADD_EN
    is_mac = is_mac_op(md_op);
`else
    is_mac = 1'b0;
`endif
    op_ok  = is_mul || is_div || is_mt || is_mac;
    accept = startE && E_valid && !flush && !busy && op_ok;
  end

  md_div_core u_div (
    .a   (a_q),
    .b   (b_q),
    .sgn (op_q == MD_DIV),
    .quo (dq),
    .rem (dr)
  );

  always_comb begin
    prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    prod_u = {32'd0, a_q} * {32'd0, b_q};
    acc    = {HI, LO};
    unique case (op_q)
      MD_MULT:  result = prod_s;
      MD_MULTU: result = prod_u;
      MD_DIV,
      MD_DIVU:  result = {dr, dq};
`ifdef MD_MADD_EN
      // Accumulate against HI/LO as they stand at commit time.
      MD_MADD:  result = acc + prod_s;
      MD_MADDU: result = acc + prod_u;
      MD_MSUB:  result = acc - prod_s;
      MD_MSUBU: result = acc - prod_u;
`endif
      default:  result = acc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      HI   <= '0;
      LO   <= '0;
      busy <= 1'b0;
      cnt  <= '0;
      op_q <= MD_NONE;
      a_q  <= '0;
      b_q  <= '0;
    end else if (busy) begin
      if (cnt == '0) begin
        busy     <= 1'b0;
        {HI, LO} <= result;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end else if (accept) begin
      if (is_mt) begin
        if (md_op == MD_MTHI) HI <= srcA;
        else                  LO <= srcA;
      end else begin
        busy <= 1'b1;
        cnt  <= is_div ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
        op_q <= md_op;
        a_q  <= srcA;
        b_q  <= srcB;
      end
    end
  end

  assign hl_out = hl_sel ? HI : LO;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: directed ops push expected HI/LO and busy length;
// a negedge monitor pops and compares when busy drops.
module tb_md_unit;
  import md_unit_pkg::*;

  logic        clk = 1'b0;
  logic        resetn, startE, E_valid, flush, hl_sel, busy;
  logic [3:0]  md_op;
  logic [31:0] srcA, srcB, HI, LO, hl_out;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
    string       name;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;
  int   run    = 0;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .resetn(resetn), .startE(startE), .md_op(md_op),
    .srcA(srcA), .srcB(srcB), .E_valid(E_valid), .flush(flush),
    .hl_sel(hl_sel), .busy(busy), .HI(HI), .LO(LO), .hl_out(hl_out)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Monitor: count busy cycles, compare on completion.
  always @(negedge clk) begin
    if (!resetn) begin
      run = 0;
    end else if (busy) begin
      run++;
      if (startE && E_valid) begin
        errors++;
        $display("FAIL protocol: startE issued while busy");
      end
    end else if (run > 0) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected completion: HI=%08h LO=%08h", HI, LO);
      end else begin
        exp_t e;
        e = expq.pop_front();
        cmp({e.name, " busy_cycles"}, 32'(run), 32'(e.cyc));
        cmp({e.name, " HI"}, HI, e.hi);
        cmp({e.name, " LO"}, LO, e.lo);
      end
      run = 0;
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    startE  = 1'b1;
    E_valid = 1'b1;
    md_op   = op;
    srcA    = a;
    srcB    = b;
    @(posedge clk); #1;
    startE  = 1'b0;
    md_op   = MD_NONE;
  endtask

  task automatic expect_op(input string name, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                           input int cyc);
    exp_t e;
    e.hi = hi; e.lo = lo; e.cyc = cyc; e.name = name;
    expq.push_back(e);
    issue(op, a, b);
    wait_done(name);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (expq.size() != 0 && n < 40) begin
      @(posedge clk); #2;
      n++;
    end
    if (expq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: pending=%0d required=0", name, expq.size());
      expq.delete();
    end
  endtask

  task automatic check_hl(input string name, input logic [31:0] hi, input logic [31:0] lo);
    hl_sel = 1'b1;
    @(negedge clk);
    cmp({name, " hl_out(HI)"}, hl_out, hi);
    hl_sel = 1'b0;
    #1;
    cmp({name, " hl_out(LO)"}, hl_out, lo);
  endtask

  initial begin
    resetn = 1'b0; startE = 1'b0; E_valid = 1'b0; flush = 1'b0; hl_sel = 1'b0;
    md_op = MD_NONE; srcA = '0; srcB = '0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    cmp("reset busy", {31'd0, busy}, 32'd0);
    cmp("reset HI", HI, 32'd0);
    cmp("reset LO", LO, 32'd0);
    @(posedge clk); #1;

    expect_op("MULT", MD_MULT, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5);
    check_hl("MULT", 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    expect_op("MULTU", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 5);
    expect_op("MULT 2^16^2", MD_MULT, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0, 5);
    expect_op("DIV -7/2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    expect_op("DIV 7/-2", MD_DIV, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10);
    expect_op("DIV ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 10);
    expect_op("DIV -5/0", MD_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 10);
    expect_op("DIVU 5/0", MD_DIVU, 32'd5, 32'd0, 32'h0000_0005, 32'hFFFF_FFFF, 10);
    expect_op("DIVU big", MD_DIVU, 32'hFFFF_FFFF, 32'h10, 32'h0000_000F, 32'h0FFF_FFFF, 10);

    issue(MD_MTHI, 32'h0000_1234, 32'h0);
    hl_sel = 1'b1;
    @(negedge clk);
    cmp("MTHI busy", {31'd0, busy}, 32'd0);
    cmp("MTHI hl_out", hl_out, 32'h0000_1234);
    @(posedge clk); #1;
    issue(MD_MTLO, 32'h0000_5678, 32'h0);
    hl_sel = 1'b0;
    @(negedge clk);
    cmp("MTLO hl_out", hl_out, 32'h0000_5678);
    @(posedge clk); #1;

    flush = 1'b1;
    issue(MD_MULT, 32'd3, 32'd4);
    flush = 1'b0;
    repeat (3) begin
      @(negedge clk);
      cmp("flush busy", {31'd0, busy}, 32'd0);
    end
    cmp("flush HI", HI, 32'h0000_1234);
    cmp("flush LO", LO, 32'h0000_5678);
    @(posedge clk); #1;

    issue(MD_MULT, 32'd3, 32'd5);
    @(posedge clk); #1;
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    cmp("rst-mid busy", {31'd0, busy}, 32'd0);
    cmp("rst-mid HI", HI, 32'd0);
    cmp("rst-mid LO", LO, 32'd0);
    repeat (8) @(negedge clk);
    cmp("rst-mid no commit HI", HI, 32'd0);
    cmp("rst-mid no commit LO", LO, 32'd0);
    @(posedge clk); #1;

    issue(MD_MTHI, 32'h0, 32'h0);
    issue(MD_MTLO, 32'hFFFF_FFFF, 32'h0);
`ifdef MD_MADD_EN
    expect_op("MADDU", MD_MADDU, 32'd1, 32'd1, 32'h0000_0001, 32'h0, 5);
`else
    issue(MD_MADDU, 32'd1, 32'd1);
    repeat (3) begin
      @(negedge clk);
      cmp("MADDU off busy", {31'd0, busy}, 32'd0);
    end
    repeat (4) @(negedge clk);
    cmp("MADDU off HI", HI, 32'h0);
    cmp("MADDU off LO", LO, 32'hFFFF_FFFF);
`endif

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

endmodule
